// File: rtl/riscv_mc_sequencer.sv
// Multicycle control sequencer for the RV32 core: fetch/exec/mem/mdu/writeback
// phases with bus-wait timeouts and a trap state in place of fatal illegal-opcode handling.
module riscv_mc_sequencer #(
    parameter int TIMEOUT_W   = 8,
    parameter int ENABLE_M    = 0,
    parameter int SKIP_WB     = 1,
    parameter int TRAP_STICKY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [6:0] f7,
    input  logic       stall,
    input  logic       ibus_ack,
    input  logic       dbus_ack,
    input  logic       mdu_done,
    output logic       ibus_req,
    output logic       dbus_req,
    output logic       dbus_we,
    output logic       mdu_start,
    output logic       load_ir,
    output logic       en_pc_counter,
    output logic       write_back_stage,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       trap_redirect,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH_REQ  = 4'd1;
    localparam logic [3:0] S_FETCH_WAIT = 4'd2;
    localparam logic [3:0] S_LOAD_IR    = 4'd3;
    localparam logic [3:0] S_EXEC       = 4'd4;
    localparam logic [3:0] S_MEM        = 4'd5;
    localparam logic [3:0] S_MDU        = 4'd6;
    localparam logic [3:0] S_WRITEBACK  = 4'd7;
    localparam logic [3:0] S_TRAP       = 4'd8;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IBUS    = 2'd2;
    localparam logic [1:0] CAUSE_DBUS    = 2'd3;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [3:0]           state, state_next;
    logic [TIMEOUT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [1:0]           cause, cause_next;

    logic is_muldiv, is_m_ok, is_load, is_store, is_branch, is_seq_alu, is_legal;

    // Opcode classification; MUL/DIV shares the ALU opcode and is told apart by f7.
    always_comb begin
        is_muldiv  = (opcode == OP_ALU) && (f7 == F7_MULDIV);
        is_m_ok    = is_muldiv && (ENABLE_M != 0);
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        is_branch  = (opcode == OP_BRANCH);
        is_seq_alu = ((opcode == OP_ALU) && !is_muldiv) || (opcode == OP_ALUI) ||
                     (opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                     (opcode == OP_JAL) || (opcode == OP_JALR);
        is_legal   = is_seq_alu || is_branch || is_load || is_store || is_m_ok;
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cause_next = cause;
        if (!stall) begin
            case (state)
                S_FETCH_REQ: begin
                    state_next = S_FETCH_WAIT;
                    cnt_next   = '0;
                end
                S_FETCH_WAIT: begin
                    if (ibus_ack) begin
                        state_next = S_LOAD_IR;
                    end else begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_next = S_TRAP;
                            cause_next = CAUSE_IBUS;
                        end
                    end
                end
                S_LOAD_IR: begin
                    cnt_next   = '0;
                    state_next = S_EXEC;
                end
                S_EXEC: begin
                    if (!is_legal) begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end else if (is_load || is_store) begin
                        state_next = S_MEM;
                        cnt_next   = '0;
                    end else if (is_m_ok) begin
                        state_next = S_MDU;
                    end else if (is_branch && (SKIP_WB != 0)) begin
                        state_next = S_FETCH_REQ;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (dbus_ack) begin
                        if (is_store && (SKIP_WB != 0))
                            state_next = S_FETCH_REQ;
                        else
                            state_next = S_WRITEBACK;
                    end else begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_next = S_TRAP;
                            cause_next = CAUSE_DBUS;
                        end
                    end
                end
                S_MDU: begin
                    if (mdu_done)
                        state_next = S_WRITEBACK;
                end
                S_WRITEBACK: state_next = S_FETCH_REQ;
                S_TRAP: begin
                    if (TRAP_STICKY == 0)
                        state_next = S_FETCH_REQ;
                end
                default: state_next = S_FETCH_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH_REQ;
            cnt   <= '0;
            cause <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cause <= cause_next;
        end
    end

    // Event-type strobes (start pulse, ack-qualified PC update, redirect) are
    // gated by stall so they fire once, on the cycle the transition is taken.
    always_comb begin
        ibus_req         = 1'b0;
        dbus_req         = 1'b0;
        dbus_we          = 1'b0;
        mdu_start        = 1'b0;
        load_ir          = 1'b0;
        en_pc_counter    = 1'b0;
        write_back_stage = 1'b0;
        trap             = 1'b0;
        trap_redirect    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH_REQ:  ibus_req = 1'b1;
                S_FETCH_WAIT: ibus_req = 1'b1;
                S_LOAD_IR:    load_ir  = 1'b1;
                S_EXEC: begin
                    en_pc_counter = is_seq_alu || is_branch;
                    mdu_start     = is_m_ok && !stall;
                end
                S_MEM: begin
                    dbus_req      = 1'b1;
                    dbus_we       = is_store;
                    en_pc_counter = dbus_ack && !stall;
                end
                S_MDU:       en_pc_counter    = mdu_done && !stall;
                S_WRITEBACK: write_back_stage = !(is_store || is_branch);
                S_TRAP: begin
                    trap          = 1'b1;
                    trap_redirect = (TRAP_STICKY == 0) && !stall;
                end
                default: ;
            endcase
        end
    end

    assign trap_cause = cause;
    assign state_o    = state;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Randomised self-checking bench: a per-instruction trace model predicts
// every cycle's state and strobes, which are compared against the sequencer.
module tb_riscv_mc_sequencer;

    localparam int TW   = 3;
    localparam int WMAX = (1 << TW) - 1;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk, rst, stall, ibus_ack, dbus_ack, mdu_done;
    logic [6:0] opcode, f7;
    logic       ibus_req, dbus_req, dbus_we, mdu_start, load_ir;
    logic       en_pc_counter, write_back_stage, trap, trap_redirect;
    logic [1:0] trap_cause;
    logic [3:0] state_o;

    int checks, errors;

    riscv_mc_sequencer #(
        .TIMEOUT_W  (TW),
        .ENABLE_M   (1),
        .SKIP_WB    (1),
        .TRAP_STICKY(0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .opcode          (opcode),
        .f7              (f7),
        .stall           (stall),
        .ibus_ack        (ibus_ack),
        .dbus_ack        (dbus_ack),
        .mdu_done        (mdu_done),
        .ibus_req        (ibus_req),
        .dbus_req        (dbus_req),
        .dbus_we         (dbus_we),
        .mdu_start       (mdu_start),
        .load_ir         (load_ir),
        .en_pc_counter   (en_pc_counter),
        .write_back_stage(write_back_stage),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .trap_redirect   (trap_redirect),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op, fs;
        logic       rst, stall, ia, da, md;
        logic [3:0] st;
        logic       ireq, dreq, dwe, ms, lir, pc, wb, tr, trd;
        logic [1:0] cause;
    } cyc_t;

    cyc_t       exp_q[$];
    logic [1:0] m_cause;

    // The three strobes that drive datapath writes must never overlap.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones({load_ir, en_pc_counter, write_back_stage}) > 1) begin
                errors++;
                $display("[TB] FAIL strobe_exclusive t=%0t: got lir/pc/wb=%b%b%b, at most one high required",
                         $time, load_ir, en_pc_counter, write_back_stage);
            end
        end
    end

    function automatic cyc_t blank(input logic [3:0] st, input logic [6:0] op, input logic [6:0] fs);
        cyc_t c;
        c       = '{default: '0};
        c.op    = op;
        c.fs    = fs;
        c.st    = st;
        c.cause = m_cause;
        c.ia    = 1'($urandom_range(0, 1));
        c.da    = 1'($urandom_range(0, 1));
        c.md    = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic logic [14:0] pack(input cyc_t c);
        return {c.st, c.ireq, c.dreq, c.dwe, c.ms, c.lir, c.pc, c.wb, c.tr, c.cause, c.trd};
    endfunction

    task automatic push_trap(input logic [1:0] why, input logic [6:0] op, input logic [6:0] fs);
        cyc_t c;
        m_cause = why;
        c       = blank(4'd8, op, fs);
        c.tr    = 1'b1;
        c.trd   = 1'b1;
        exp_q.push_back(c);
    endtask

    // Expected cycle trace for one instruction on this configuration
    // (M extension on, no-destination writeback skipped, one-cycle trap then refetch).
    task automatic build(input logic [6:0] op, input logic [6:0] fs, input int iw, input int dw,
                         input int mw, input int stl);
        cyc_t c;
        logic muldiv, mem, store, branch, plain, legal;
        muldiv = (op == OP_ALU) && (fs == 7'b0000001);
        store  = (op == OP_STORE);
        branch = (op == OP_BRANCH);
        mem    = (op == OP_LOAD) || store;
        plain  = (op inside {OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) && !muldiv;
        legal  = plain || muldiv || mem || branch;

        c = blank(4'd1, op, fs); c.ireq = 1'b1; exp_q.push_back(c);
        for (int i = 0; i < iw && i < WMAX; i++) begin
            c = blank(4'd2, op, fs); c.ia = 1'b0; c.ireq = 1'b1; exp_q.push_back(c);
        end
        if (iw >= WMAX) begin push_trap(2'd2, op, fs); return; end
        c = blank(4'd2, op, fs); c.ia = 1'b1; c.ireq = 1'b1; exp_q.push_back(c);
        c = blank(4'd3, op, fs); c.lir = 1'b1; exp_q.push_back(c);

        c = blank(4'd4, op, fs);
        if (!legal) begin exp_q.push_back(c); push_trap(2'd1, op, fs); return; end
        c.pc = plain || branch;
        c.ms = muldiv;
        exp_q.push_back(c);

        if (mem) begin
            for (int i = 0; i < dw && i < WMAX; i++) begin
                c = blank(4'd5, op, fs); c.da = 1'b0; c.dreq = 1'b1; c.dwe = store; exp_q.push_back(c);
            end
            if (dw >= WMAX) begin push_trap(2'd3, op, fs); return; end
            for (int s = 0; s < stl; s++) begin
                c = blank(4'd5, op, fs); c.stall = 1'b1; c.da = 1'b1; c.dreq = 1'b1; c.dwe = store;
                exp_q.push_back(c);
            end
            c = blank(4'd5, op, fs); c.da = 1'b1; c.dreq = 1'b1; c.dwe = store; c.pc = 1'b1;
            exp_q.push_back(c);
            if (store) return;
        end else if (muldiv) begin
            for (int i = 0; i < mw; i++) begin
                c = blank(4'd6, op, fs); c.md = 1'b0; exp_q.push_back(c);
            end
            c = blank(4'd6, op, fs); c.md = 1'b1; c.pc = 1'b1; exp_q.push_back(c);
        end else if (branch) begin
            return;
        end
        c = blank(4'd7, op, fs); c.wb = 1'b1; exp_q.push_back(c);
    endtask

    task automatic step(input cyc_t c, output logic [14:0] obs);
        rst      = c.rst;
        stall    = c.stall;
        opcode   = c.op;
        f7       = c.fs;
        ibus_ack = c.ia;
        dbus_ack = c.da;
        mdu_done = c.md;
        #1;
        obs = {state_o, ibus_req, dbus_req, dbus_we, mdu_start, load_ir, en_pc_counter,
               write_back_stage, trap, trap_cause, trap_redirect};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            c = blank(4'd1, 7'($urandom), 7'($urandom)); c.rst = 1'b1; c.cause = 2'd0; c.ia = 1'b1;
            exp_q.push_back(c);
        end
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL reset cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_alu_zero_wait;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        build(OP_ALU, 7'b0000000, 0, 0, 0, 0);
        build(OP_ALU, 7'b0100000, 0, 0, 0, 0);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front(); c.ia = 1'b1;
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL alu_zero_wait cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_load_store;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        build(OP_LOAD, 7'($urandom), 0, 3, 0, 0);
        build(OP_STORE, 7'($urandom), 0, 0, 0, 0);
        build(OP_STORE, 7'($urandom), 2, 2, 0, 0);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL load_store cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_illegal_trap;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        build(7'b0000000, 7'b0000000, 0, 0, 0, 0);
        build(OP_BRANCH, 7'($urandom), 1, 0, 0, 0);
        build(7'b1111111, 7'($urandom), 0, 0, 0, 0);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL illegal_trap cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_timeouts;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        build(OP_ALU, 7'b0000000, WMAX, 0, 0, 0);
        build(OP_ALUI, 7'($urandom), WMAX - 1, 0, 0, 0);
        build(OP_LOAD, 7'($urandom), 0, WMAX - 1, 0, 0);
        build(OP_STORE, 7'($urandom), 0, WMAX, 0, 0);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL timeouts cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_wait;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        c = blank(4'd1, OP_ALU, 7'd0); c.ireq = 1'b1; exp_q.push_back(c);
        for (int i = 0; i < 3; i++) begin
            c = blank(4'd2, OP_ALU, 7'd0); c.ia = 1'b0; c.ireq = 1'b1; exp_q.push_back(c);
        end
        c = blank(4'd2, OP_ALU, 7'd0); c.rst = 1'b1; c.ia = 1'b1; exp_q.push_back(c);
        m_cause = 2'd0;
        build(OP_ALU, 7'd0, WMAX, 0, 0, 0);
        build(OP_LUI, 7'($urandom), 1, 0, 0, 0);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL reset_mid_wait cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_mdu;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        build(OP_ALU, 7'b0000001, 0, 0, 10, 0);
        build(OP_ALU, 7'b0000001, 1, 0, 0, 0);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL mdu cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_stall;
        cyc_t c;
        logic [14:0] obs;
        int n = 0;
        build(OP_LOAD, 7'($urandom), 0, 1, 0, 2);
        build(OP_STORE, 7'($urandom), 0, 0, 0, 3);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL stall cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    task automatic test_back_to_back;
        cyc_t c;
        logic [14:0] obs;
        logic [6:0] ops[9] = '{OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
                               OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        logic [6:0] op, fs;
        int n = 0;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 7'($urandom);
                while (op inside {ops}) op = 7'($urandom);
            end else begin
                op = ops[$urandom_range(0, 8)];
            end
            fs = ($urandom_range(0, 3) == 0) ? 7'b0000001 : 7'($urandom);
            build(op, fs, int'($urandom_range(0, WMAX + 1)), int'($urandom_range(0, WMAX + 1)),
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 2)));
        end
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            step(c, obs);
            checks++;
            if (obs !== pack(c)) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc %0d: got state %0d out %b, expected state %0d out %b",
                         n, obs[14:11], obs, c.st, pack(c));
            end
            n++;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_cause  = 2'd0;
        rst      = 1'b1;
        stall    = 1'b0;
        ibus_ack = 1'b0;
        dbus_ack = 1'b0;
        mdu_done = 1'b0;
        opcode   = 7'd0;
        f7       = 7'd0;
        test_reset;
        test_alu_zero_wait;
        test_load_store;
        test_illegal_trap;
        test_timeouts;
        test_reset_mid_wait;
        test_mdu;
        test_stall;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mc_sequencer.md
Name: riscv_mc_sequencer

Overview:
Parametrised multicycle sequencer for the RV32 core, the next generation of the fixed four-phase control FSM. It adds:
- variable-latency instruction and data bus handshakes with timeout,
- an optional multi-cycle MUL/DIV wait,
- a writeback-skip mode,
- a trap state that replaces simulation-fatal handling of illegal opcodes.

It drives phase strobes to PC, IR, register file and bus adapters. Datapath mux decode stays in the existing decoder.

Parameters:
- TIMEOUT_W, 8: width of the bus-wait timeout counter; timeout at 2**TIMEOUT_W-1 wait cycles.
- ENABLE_M, 0: 1 = opcode 0110011 with f7=0000001 is a MUL/DIV that waits for mdu_done; 0 = that encoding is illegal.
- SKIP_WB, 1: 1 = instructions with no destination (STORE, BRANCH) bypass WRITEBACK.
- TRAP_STICKY, 1: 1 = TRAP holds until reset; 0 = TRAP returns to FETCH_REQ after one cycle with trap_redirect=1.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- opcode  in  7  IR[6:0], valid from EXEC onward
- f7  in  7  IR[31:25]
- stall  in  1  global freeze; holds state and counter; strobes still decode from the held state
- ibus_ack  in  1  instruction word valid this cycle
- dbus_ack  in  1  data access complete this cycle
- mdu_done  in  1  MUL/DIV result valid
- ibus_req  out  1  instruction fetch request, level
- dbus_req  out  1  data request, level
- dbus_we  out  1  write qualifier, valid while dbus_req=1
- mdu_start  out  1  one-cycle start pulse
- load_ir  out  1  IR capture strobe
- en_pc_counter  out  1  PC update strobe
- write_back_stage  out  1  register-file write enable
- trap  out  1  high while in TRAP
- trap_cause  out  2  0 none, 1 illegal opcode, 2 ibus timeout, 3 dbus timeout
- trap_redirect  out  1  one-cycle pulse on TRAP exit (TRAP_STICKY=0 only)
- state_o  out  4  current state encoding, for debug/trace

Behaviour:
- State encodings: FETCH_REQ=1, FETCH_WAIT=2, LOAD_IR=3, EXEC=4, MEM=5, MDU=6, WRITEBACK=7, TRAP=8.
- Reset, sync, rst=1 at clk edge; rst has priority over stall:
  - state=FETCH_REQ, wait counter=0, trap_cause=0.
  - All strobe outputs are 0 during the rst cycle (combinational strobes forced 0 while rst=1).
  - Reset mid-bus-wait abandons the access; no ack is remembered.
- Valid opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- Transitions, taken only when stall=0:
  - FETCH_REQ: ibus_req=1; go to FETCH_WAIT.
  - FETCH_WAIT: ibus_req=1.
    - ibus_ack=1 -> LOAD_IR.
    - Else counter increments; at counter = 2**TIMEOUT_W-1 -> TRAP, cause 2.
  - LOAD_IR: load_ir=1; counter cleared; go to EXEC.
  - EXEC: en_pc_counter=1 only for ALU, ALUI, LUI, AUIPC, JAL, JALR, BRANCH; these take the path below.
    - LOAD/STORE -> MEM.
    - MUL/DIV with ENABLE_M=1 -> MDU; mdu_start=1 this cycle.
    - Illegal opcode -> TRAP, cause 1; en_pc_counter=0.
    - STORE/BRANCH with SKIP_WB=1 -> FETCH_REQ; otherwise -> WRITEBACK.
  - MEM: dbus_req=1; dbus_we = opcode==0100011.
    - dbus_ack=1 -> en_pc_counter=1 that cycle.
      - LOAD -> WRITEBACK.
      - STORE -> FETCH_REQ if SKIP_WB=1, else WRITEBACK.
    - Timeout as in FETCH_WAIT -> TRAP, cause 3.
  - MDU: waits unbounded.
    - mdu_done=1 -> en_pc_counter=1; go to WRITEBACK.
  - WRITEBACK: write_back_stage=1 unless opcode is STORE or BRANCH; go to FETCH_REQ.
  - TRAP: trap=1.
    - TRAP_STICKY=1: remain until rst.
    - TRAP_STICKY=0: next state FETCH_REQ, trap_redirect=1 in the TRAP cycle, trap_cause held until the next trap or reset.
- Ack handling:
  - An ack arriving in the same cycle as stall=1 is ignored; the bus side must hold ack until taken.
  - An ack outside its wait state is ignored.
- Counter:
  - Saturates, never wraps.
  - Cleared on every transition into FETCH_WAIT or MEM.
- Latency, zero-wait bus:
  - ALU: 5 cycles (FETCH_REQ, FETCH_WAIT, LOAD_IR, EXEC, WRITEBACK).
  - LOAD: 6 cycles.
  - STORE: 5 cycles with SKIP_WB=1.
- Strobe exclusivity: at most one of load_ir, en_pc_counter, write_back_stage is high in any cycle. This is asserted in the bench.

Test Plan:
- Zero-wait ALU: ibus_ack tied 1, opcode 0110011 -> state_o sequence 1,2,3,4,7,1; write_back_stage high exactly in cycle 5.
- LOAD with dbus_ack after 3 cycles: dbus_req high 4 cycles, dbus_we=0, then WRITEBACK. STORE with SKIP_WB=1: dbus_we=1, no WRITEBACK, returns to state 1.
- Illegal opcode 0000000: trap=1, trap_cause=1, en_pc_counter never pulses. TRAP_STICKY=0: trap_redirect pulse, then state_o=1.
- TIMEOUT_W=3, ibus_ack held 0: TRAP entered after 7 FETCH_WAIT cycles, trap_cause=2. Same for dbus gives cause 3.
- ENABLE_M=1, f7=0000001, mdu_done after 10 cycles: single mdu_start pulse in EXEC; en_pc_counter in the mdu_done cycle; WRITEBACK follows.
- stall raised in MEM with dbus_ack=1 for 2 cycles: state stays 5. rst asserted during FETCH_WAIT: next state_o=1, counter=0, all strobes 0.
